// File: rtl/if_stage_pkg.sv
// Shared constants for the fetch stage: address map, handler entry and ExcCodes.
package if_stage_pkg;

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] IMEM_BASE  = 32'h0000_3000;
  localparam logic [31:0] IMEM_BYTES = 32'h0000_4000;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] NOP = 32'h0000_0000;

  // Upper bound computed in 33 bits so base + size can never wrap.
  function automatic logic fetch_bad(input logic [31:0] addr);
    logic [32:0] limit;
    limit = {1'b0, IMEM_BASE} + {1'b0, IMEM_BYTES};
    return (addr[1:0] != 2'b00) || (addr < IMEM_BASE) || ({1'b0, addr} >= limit);
  endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall holds, otherwise latch fetch.
module if_id_reg
  import if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  input  logic [4:0]  exc_in,
  input  logic        bd_in,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [4:0]  exc_d,
  output logic        bd_d
);

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_d <= NOP;
      pc_d    <= RESET_PC;
      exc_d   <= 5'd0;
      bd_d    <= 1'b0;
    end else if (flush) begin
      // Flushed slot carries the new fetch PC so D sees a consistent bubble.
      instr_d <= NOP;
      pc_d    <= flush_pc;
      exc_d   <= 5'd0;
      bd_d    <= 1'b0;
    end else if (!stall) begin
      instr_d <= instr_in;
      pc_d    <= pc_in;
      exc_d   <= exc_in;
      bd_d    <= bd_in;
    end
  end

endmodule

// File: rtl/if_stage.sv
// MIPS fetch stage: PC register, next-PC select, AdEL detection, IF/ID register.
module if_stage
  import if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        branch_in_d,
  input  logic        exc_req,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic [31:0] instr_f,
  output logic [31:0] pc_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc8_d,
  output logic [4:0]  exc_d,
  output logic        bd_d
);

  logic        adel;
  logic [31:0] fetched_word;
  logic [4:0]  fetched_exc;
  logic [31:0] pc_next;
  logic        flush;
  logic [31:0] flush_pc;

  assign adel         = fetch_bad(pc_f);
  assign fetched_word = adel ? NOP : instr_f;
  assign fetched_exc  = adel ? EXC_ADEL : 5'd0;

  assign flush    = exc_req | eret;
  assign flush_pc = exc_req ? HANDLER_PC : epc;

  always_comb begin
    pc_next = pc_f + 32'd4;
    if (exc_req)       pc_next = HANDLER_PC;
    else if (eret)     pc_next = epc;
    else if (stall)    pc_next = pc_f;
    else if (redirect) pc_next = redirect_pc;
  end

  always_ff @(posedge clk) begin
    if (reset) pc_f <= RESET_PC;
    else       pc_f <= pc_next;
  end

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .reset    (reset),
    .stall    (stall),
    .flush    (flush),
    .flush_pc (flush_pc),
    .instr_in (fetched_word),
    .pc_in    (pc_f),
    .exc_in   (fetched_exc),
    .bd_in    (branch_in_d),
    .instr_d  (instr_d),
    .pc_d     (pc_d),
    .exc_d    (exc_d),
    .bd_d     (bd_d)
  );

  assign pc8_d = pc_d + 32'd8;

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Fetch stage of the 5-stage MIPS pipeline, directly upstream of the instruction memory.
- Holds the PC register and drives the fetch address to instruction memory.
- Detects fetch address errors (AdEL) and latches the fetched word into the IF/ID pipeline register.
- Selects the next PC from: sequential +4, the D-stage branch/jump redirect, exception-handler entry, and eret return to EPC.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- HANDLER_PC, 32'h0000_4180, exception/interrupt handler entry address.
- IMEM_BASE, 32'h0000_3000, lowest legal fetch address.
- IMEM_BYTES, 32'h0000_4000, size of the fetchable region in bytes (4096 words).
- EXC_ADEL, 5'd4, ExcCode reported for a bad fetch address.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- stall  in  1  hazard stall; hold PC and IF/ID
- redirect  in  1  D-stage branch taken or jump; next PC = redirect_pc
- redirect_pc  in  32  branch/jump target
- branch_in_d  in  1  instruction now in D is a branch/jump; current F word is its delay slot
- exc_req  in  1  CP0 exception/interrupt taken this cycle
- eret  in  1  eret committed this cycle
- epc  in  32  CP0 EPC
- instr_f  in  32  word returned by instruction memory for pc_f (combinational)
- pc_f  out  32  current fetch address to instruction memory
- instr_d  out  32  IF/ID instruction
- pc_d  out  32  IF/ID PC
- pc8_d  out  32  pc_d + 8 (link address)
- exc_d  out  5  IF/ID ExcCode; 0 = none
- bd_d  out  1  IF/ID delay-slot flag

Behaviour:
- Reset (synchronous, highest priority):
  - pc_f <= RESET_PC.
  - instr_d <= 0, pc_d <= RESET_PC, exc_d <= 0, bd_d <= 0.
- Fetch check (combinational on pc_f):
  - adel = (pc_f[1:0] != 0) or (pc_f < IMEM_BASE) or (pc_f >= IMEM_BASE + IMEM_BYTES).
  - Unsigned 32-bit compares.
  - The upper-bound sum must not wrap; compute it in 33 bits.
  - fetched word = adel ? 32'h0 : instr_f.
  - fetched exc = adel ? EXC_ADEL : 0.
- Next-PC priority, evaluated per rising edge:
  1. reset
  2. exc_req: pc_f <= HANDLER_PC
  3. eret: pc_f <= epc
  4. stall: pc_f holds
  5. redirect: pc_f <= redirect_pc
  6. otherwise: pc_f <= pc_f + 4, wrapping mod 2^32
- IF/ID register, same priority:
  - exc_req or eret (flush): instr_d <= 0, exc_d <= 0, bd_d <= 0, pc_d <= next pc_f (HANDLER_PC or epc).
    - The flush wins over stall.
    - eret has no delay slot.
  - stall: all IF/ID outputs hold.
  - otherwise: instr_d <= fetched word, pc_d <= pc_f, exc_d <= fetched exc, bd_d <= branch_in_d.
    - A redirect cycle still latches the delay-slot word.
- pc8_d is combinational: pc_d + 8.
- Latency:
  - A PC presented on pc_f appears on pc_d/instr_d one cycle later, absent stall or flush.
  - A redirect takes effect on pc_f at the next edge, so exactly one delay-slot word is fetched.
- Boundary conditions:
  - redirect with stall: the redirect is ignored. D re-presents it after the stall releases.
  - exc_req together with eret: exc_req wins.
  - A misaligned redirect_pc or epc is loaded unchanged. AdEL is flagged when it is fetched.
  - reset mid-stall or mid-flush: reset wins with no residual state.
- No state beyond the PC register and the IF/ID register.

Decomposition:
- Shared package constants: RESET_PC, HANDLER_PC, IMEM_BASE, IMEM_BYTES, ExcCode values (AdEL=4, Int=0, RI=10, Ov=12).
- NOP encoding is 32'h0.
- One natural sub-module: if_id_reg (IF/ID pipeline register with stall/flush). The PC register and next-PC mux stay in if_stage.

Test Plan:
- Reset, then 4 free-running cycles with memory words A0..A3:
  - pc_f goes 3000, 3004, 3008, 300C.
  - pc_d lags pc_f by one cycle.
  - pc8_d = 3008 when pc_d = 3000.
  - exc_d = 0.
- Branch: branch_in_d = 1 while the delay slot is fetched at 3008, with redirect = 1 and redirect_pc = 3100 in the same cycle:
  - Next edge: pc_d = 3008, bd_d = 1, pc_f = 3100.
- Stall asserted 2 cycles at pc_f = 3010, with a simultaneous redirect in the first cycle:
  - pc_f and all IF/ID outputs hold.
  - The redirect is ignored.
  - After release, pc_f = 3014.
- exc_req with stall at pc_f = 3020:
  - pc_f = 4180, instr_d = 0, pc_d = 4180, bd_d = 0.
  - Then eret with epc = 3024: pc_f = 3024 and IF/ID is flushed.
- redirect_pc = 3002, then redirect_pc = 7000:
  - Each: instr_d = 0 and exc_d = 4 on the next edge.
  - pc_d = the bad address.
- reset asserted mid-flush with exc_req = 1:
  - pc_f = 3000, all IF/ID outputs at reset values.
